// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - Four-digit multiplexed 7-segment scan driver with tear-free shadow registers
//
// Purpose: time-multiplexes four digit codes onto one active-low segment bus.
//   Each digit owns a slot of DIV cycles. The first BLANK cycles of every slot
//   keep all anodes off as dead-time. Digit codes are captured into shadow
//   registers only at the frame wrap, so a frame never mixes old and new values.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   en          scan enable; when low the scan position freezes and the display blanks
//   dig6..dig1  digit codes (0-9 numeral, 11 minus, others blank)
//   seg         {g,f,e,d,c,b,a}, active-low, registered
//   an          digit select, active-low; an[3]=dig6 ... an[0]=dig1, registered
//   frame_done  one-cycle pulse following the edge that loads the shadows
module seg_scan_driver #(
  parameter int DIV   = 50000,
  parameter int BLANK = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] dig6,
  input  logic [3:0] dig4,
  input  logic [3:0] dig2,
  input  logic [3:0] dig1,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int            CW        = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
  localparam logic [3:0]    CODE_BLANK = 4'hA;

  logic [CW-1:0] count_q, count_d;
  logic [1:0]    slot_q, slot_d;
  logic [3:0]    shadow_q [4];
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          frame_done_q;
  logic          frame_wrap;

  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      4'd11:   decode = 7'h3F;
      default: decode = 7'h7F;
    endcase
  endfunction

  // Last cycle of slot 3: the only edge that refreshes the shadows.
  assign frame_wrap = en && (count_q == CNT_LAST) && (slot_q == 2'd3);

  always_comb begin
    count_d = count_q;
    slot_d  = slot_q;
    an_d    = 4'hF;
    seg_d   = 7'h7F;
    if (en) begin
      if (count_q == CNT_LAST) begin
        count_d = '0;
        slot_d  = slot_q + 2'd1;  // 3 rolls over to 0
      end else begin
        count_d = count_q + 1'b1;
      end
      // Outputs follow the pre-edge position; dead-time keeps every anode off.
      if (count_q >= CNT_BLANK) begin
        an_d  = ~(4'b1000 >> slot_q);
        seg_d = decode(shadow_q[slot_q]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      slot_q       <= 2'd0;
      shadow_q[0]  <= CODE_BLANK;
      shadow_q[1]  <= CODE_BLANK;
      shadow_q[2]  <= CODE_BLANK;
      shadow_q[3]  <= CODE_BLANK;
      seg_q        <= 7'h7F;
      an_q         <= 4'hF;
      frame_done_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      slot_q       <= slot_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_wrap;
      if (frame_wrap) begin
        shadow_q[0] <= dig6;
        shadow_q[1] <= dig4;
        shadow_q[2] <= dig2;
        shadow_q[3] <= dig1;
      end
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
